// File: rtl/jamma_input_debounce.sv
// Player-1 JAMMA input conditioning: 2-flop sync, per-bit debounce, clean levels and press/release strobes.
// Optional JAMMA_SOCD_EN masks simultaneous opposite directions (LFT+RGT, UP+DN) before strobes are derived.
module jamma_input_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] raw_n,
  output logic [7:0] btn,
  output logic [7:0] press,
  output logic [7:0] released,
  output logic       any_press
);

  // Bit order {S1, START1, UP, DN, RGT, LFT, S2, S3}; "release" is a reserved word, hence "released".
  localparam int LFT = 2;
  localparam int RGT = 3;
  localparam int DN  = 4;
  localparam int UP  = 5;

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("jamma_input_debounce: DEBOUNCE_CYCLES must be >= 2");
  end

  logic [7:0]    sync1;
  logic [7:0]    sync2;
  logic [7:0]    s;
  logic [7:0]    state;
  logic [7:0]    state_next;
  logic [7:0]    btn_next;
  logic [CW-1:0] cnt      [8];
  logic [CW-1:0] cnt_next [8];

  assign s = ~sync2;

  always_comb begin
    state_next = state;
    for (int i = 0; i < 8; i++) begin
      cnt_next[i] = '0;
      if (s[i] != state[i]) begin
        if (cnt[i] == CNT_MAX) begin
          state_next[i] = s[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    btn_next = state_next;
`ifdef JAMMA_SOCD_EN
    if (state_next[LFT] && state_next[RGT]) begin
      btn_next[LFT] = 1'b0;
      btn_next[RGT] = 1'b0;
    end
    if (state_next[UP] && state_next[DN]) begin
      btn_next[UP] = 1'b0;
      btn_next[DN] = 1'b0;
    end
`endif
  end

  // btn doubles as the one-cycle-delayed copy, so strobes line up with the new btn value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 8'hFF;
      sync2     <= 8'hFF;
      state     <= 8'h00;
      btn       <= 8'h00;
      press     <= 8'h00;
      released  <= 8'h00;
      any_press <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1     <= raw_n;
      sync2     <= sync1;
      state     <= state_next;
      btn       <= btn_next;
      press     <= btn_next & ~btn;
      released  <= ~btn_next & btn;
      any_press <= |(btn_next & ~btn);
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

endmodule

// File: tb/tb_jamma_input_debounce.sv
// Self-checking bench for jamma_input_debounce with DEBOUNCE_CYCLES=4; expected words are queued per driven cycle.
// Define JAMMA_SOCD_EN for both DUT and bench to check the opposite-direction cleaning build.
module tb_jamma_input_debounce;

  localparam int D = 4;
  localparam int LAT = D + 1;  // change first sampled at edge k shows up after edge k+1+D
`ifdef JAMMA_SOCD_EN
  localparam logic [7:0] ALL_BTN = 8'hC3;
`else
  localparam logic [7:0] ALL_BTN = 8'hFF;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] raw_n;
  logic [7:0] btn;
  logic [7:0] press;
  logic [7:0] released;
  logic       any_press;

  logic [24:0] exp_q [$];
  int tests  = 0;
  int failed = 0;

  jamma_input_debounce #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_n     (raw_n),
    .btn       (btn),
    .press     (press),
    .released  (released),
    .any_press (any_press)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    logic [24:0] e;
    for (int i = 0; i < 24; i++) begin
      rst   = (i < 4);
      raw_n = 8'hFF;
      exp_q.push_back(25'h0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      tests++;
      if ({btn, press, released, any_press} !== e) begin
        failed++;
        $display("FAIL reset cyc %0d: got btn=%h press=%h release=%h any=%b, want btn=%h press=%h release=%h any=%b",
                 i, btn, press, released, any_press, e[24:17], e[16:9], e[8:1], e[0]);
      end
    end
  endtask

  // Each phase holds one raw_n value for 10 cycles; outputs move from prev to next btn after LAT cycles.
  task automatic test_clean_press();
    logic [7:0] ph_raw [2] = '{8'hDF, 8'hFF};
    logic [7:0] ph_btn [2] = '{8'h20, 8'h00};
    logic [7:0] prev;
    logic [24:0] e;
    prev = 8'h00;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 10; i++) begin
        rst   = 1'b0;
        raw_n = ph_raw[p];
        if (i < LAT)       e = {prev, 8'h00, 8'h00, 1'b0};
        else if (i == LAT) e = {ph_btn[p], ph_btn[p] & ~prev, ~ph_btn[p] & prev, |(ph_btn[p] & ~prev)};
        else               e = {ph_btn[p], 8'h00, 8'h00, 1'b0};
        exp_q.push_back(e);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        tests++;
        if ({btn, press, released, any_press} !== e) begin
          failed++;
          $display("FAIL clean_press ph %0d cyc %0d: got btn=%h press=%h release=%h any=%b, want btn=%h press=%h release=%h any=%b",
                   p, i, btn, press, released, any_press, e[24:17], e[16:9], e[8:1], e[0]);
        end
      end
      prev = ph_btn[p];
    end
  endtask

  task automatic test_bounce();
    logic [24:0] e;
    for (int i = 0; i < 20; i++) begin
      rst   = 1'b0;
      raw_n = ((i % 4) == 3) ? 8'hFF : 8'hBF;
      exp_q.push_back(25'h0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      tests++;
      if ({btn, press, released, any_press} !== e) begin
        failed++;
        $display("FAIL bounce cyc %0d: got btn=%h press=%h release=%h any=%b, want all zero",
                 i, btn, press, released, any_press);
      end
    end
    // Held low for exactly D cycles: one press, then release after the same latency.
    for (int i = 0; i < 12; i++) begin
      rst   = 1'b0;
      raw_n = (i < D) ? 8'hBF : 8'hFF;
      e = {((i >= LAT) && (i < LAT + D)) ? 8'h40 : 8'h00,
           (i == LAT) ? 8'h40 : 8'h00,
           (i == LAT + D) ? 8'h40 : 8'h00,
           (i == LAT)};
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      tests++;
      if ({btn, press, released, any_press} !== e) begin
        failed++;
        $display("FAIL bounce_hold cyc %0d: got btn=%h press=%h release=%h any=%b, want btn=%h press=%h release=%h any=%b",
                 i, btn, press, released, any_press, e[24:17], e[16:9], e[8:1], e[0]);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] ph_raw [2] = '{8'h00, 8'hFF};
    logic [7:0] ph_btn [2] = '{ALL_BTN, 8'h00};
    logic [7:0] prev;
    logic [24:0] e;
    prev = 8'h00;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 10; i++) begin
        rst   = 1'b0;
        raw_n = ph_raw[p];
        if (i < LAT)       e = {prev, 8'h00, 8'h00, 1'b0};
        else if (i == LAT) e = {ph_btn[p], ph_btn[p] & ~prev, ~ph_btn[p] & prev, |(ph_btn[p] & ~prev)};
        else               e = {ph_btn[p], 8'h00, 8'h00, 1'b0};
        exp_q.push_back(e);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        tests++;
        if ({btn, press, released, any_press} !== e) begin
          failed++;
          $display("FAIL simultaneous ph %0d cyc %0d: got btn=%h press=%h release=%h any=%b, want btn=%h press=%h release=%h any=%b",
                   p, i, btn, press, released, any_press, e[24:17], e[16:9], e[8:1], e[0]);
        end
      end
      prev = ph_btn[p];
    end
  endtask

  task automatic test_reset_mid_count();
    logic [24:0] e;
    // 4 cycles of S3 held, then 3 reset cycles still holding, then 10 free cycles, then release.
    for (int i = 0; i < 27; i++) begin
      rst   = (i >= 4) && (i < 7);
      raw_n = (i < 17) ? 8'hFE : 8'hFF;
      if (i < 7 + LAT)        e = 25'h0;
      else if (i == 7 + LAT)  e = {8'h01, 8'h01, 8'h00, 1'b1};
      else if (i < 17 + LAT)  e = {8'h01, 8'h00, 8'h00, 1'b0};
      else if (i == 17 + LAT) e = {8'h00, 8'h00, 8'h01, 1'b0};
      else                    e = 25'h0;
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      tests++;
      if ({btn, press, released, any_press} !== e) begin
        failed++;
        $display("FAIL reset_mid_count cyc %0d: got btn=%h press=%h release=%h any=%b, want btn=%h press=%h release=%h any=%b",
                 i, btn, press, released, any_press, e[24:17], e[16:9], e[8:1], e[0]);
      end
    end
  endtask

  // LFT, then LFT+RGT, then RGT alone, then idle.
  task automatic test_socd();
    logic [7:0] ph_raw [4] = '{8'hFB, 8'hF3, 8'hF7, 8'hFF};
`ifdef JAMMA_SOCD_EN
    logic [7:0] ph_btn [4] = '{8'h04, 8'h00, 8'h08, 8'h00};
`else
    logic [7:0] ph_btn [4] = '{8'h04, 8'h0C, 8'h08, 8'h00};
`endif
    logic [7:0] prev;
    logic [24:0] e;
    prev = 8'h00;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 10; i++) begin
        rst   = 1'b0;
        raw_n = ph_raw[p];
        if (i < LAT)       e = {prev, 8'h00, 8'h00, 1'b0};
        else if (i == LAT) e = {ph_btn[p], ph_btn[p] & ~prev, ~ph_btn[p] & prev, |(ph_btn[p] & ~prev)};
        else               e = {ph_btn[p], 8'h00, 8'h00, 1'b0};
        exp_q.push_back(e);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        tests++;
        if ({btn, press, released, any_press} !== e) begin
          failed++;
          $display("FAIL socd ph %0d cyc %0d: got btn=%h press=%h release=%h any=%b, want btn=%h press=%h release=%h any=%b",
                   p, i, btn, press, released, any_press, e[24:17], e[16:9], e[8:1], e[0]);
        end
      end
      prev = ph_btn[p];
    end
  endtask

  initial begin
    rst   = 1'b1;
    raw_n = 8'hFF;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    test_socd();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
